// File: rtl/mem_arb_pkg.sv
// Shared constants and enums for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned SEL_W = 3;

  // DM starts at address 0, so only its upper bound is needed
  localparam logic [AW-1:0] DM_HI     = 32'h0000_2fff;
  localparam logic [AW-1:0] TC1_LO    = 32'h0000_7f00;
  localparam logic [AW-1:0] TC1_HI    = 32'h0000_7f0b;
  localparam logic [AW-1:0] TC2_LO    = 32'h0000_7f10;
  localparam logic [AW-1:0] TC2_HI    = 32'h0000_7f1b;
  localparam logic [AW-1:0] INT_LO    = 32'h0000_7f20;
  localparam logic [AW-1:0] INT_HI    = 32'h0000_7f23;
  localparam logic [AW-1:0] COUNT_OFF = 32'h0000_0008;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_t;

  typedef enum logic [SEL_W-1:0] {
    SEL_NONE, SEL_DM, SEL_TC1, SEL_TC2, SEL_INT
  } sel_t;

endpackage

// File: rtl/mem_arb_decode.sv
// Combinational address decode: slave select plus access error.
module mem_arb_decode
  import mem_arb_pkg::*;
(
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [BW-1:0]    byteen,
  output logic [SEL_W-1:0] sel_c,
  output logic             err_c
);

  // Timers demand full-word access and their COUNT word is read-only
  always_comb begin
    sel_c = SEL_NONE;
    err_c = 1'b0;
    if (addr <= DM_HI) begin
      sel_c = SEL_DM;
    end else if (addr >= TC1_LO && addr <= TC1_HI) begin
      sel_c = SEL_TC1;
      err_c = (byteen != 4'b1111) || (we && ((addr - TC1_LO) >= COUNT_OFF));
    end else if (addr >= TC2_LO && addr <= TC2_HI) begin
      sel_c = SEL_TC2;
      err_c = (byteen != 4'b1111) || (we && ((addr - TC2_LO) >= COUNT_OFF));
    end else if (addr >= INT_LO && addr <= INT_HI) begin
      sel_c = SEL_INT;
    end else begin
      err_c = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter, 3-cycle IDLE/ADDR/RESP transfer.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority to m0.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [BW-1:0] m0_byteen,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [BW-1:0] m1_byteen,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          m_err,
  output logic [DW-1:0] m_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic [BW-1:0] s_byteen,
  output logic          dm_we,
  output logic          tc1_we,
  output logic          tc2_we,
  output logic          int_we,
  input  logic [DW-1:0] dm_rdata,
  input  logic [DW-1:0] tc1_rdata,
  input  logic [DW-1:0] tc2_rdata,
  input  logic [DW-1:0] int_rdata,
  output logic          m0_stall
);

  state_t           state;
  logic             win;
  logic             we_q;
  logic             err_q;
  logic [SEL_W-1:0] sel_q;
  logic             pick;
  logic [AW-1:0]    c_addr;
  logic [DW-1:0]    c_wdata;
  logic [BW-1:0]    c_byteen;
  logic             c_we;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_err;
  logic             stb_ok;
  logic [DW-1:0]    rd_sel;

`ifdef MEM_ARB_RR_EN
  logic last;

  // On conflict the master not granted last wins (1 = m1)
  always_comb begin
    pick = ~m0_req;
    if (m0_req && m1_req) pick = ~last;
  end
`else
  always_comb pick = ~m0_req;
`endif

  always_comb begin
    c_addr   = pick ? m1_addr   : m0_addr;
    c_wdata  = pick ? m1_wdata  : m0_wdata;
    c_byteen = pick ? m1_byteen : m0_byteen;
    c_we     = pick ? m1_we     : m0_we;
  end

  mem_arb_decode u_decode (
    .addr   (c_addr),
    .we     (c_we),
    .byteen (c_byteen),
    .sel_c  (dec_sel),
    .err_c  (dec_err)
  );

  assign stb_ok   = c_we && !dec_err;
  assign m0_stall = m0_req & ~m0_ack;

  // Read data captured in ADDR; writes and errors return zero
  always_comb begin
    rd_sel = '0;
    if (!err_q && !we_q) begin
      case (sel_q)
        SEL_DM:  rd_sel = dm_rdata;
        SEL_TC1: rd_sel = tc1_rdata;
        SEL_TC2: rd_sel = tc2_rdata;
        SEL_INT: rd_sel = int_rdata;
        default: rd_sel = '0;
      endcase
    end
  end

  // Strobes are registered on entry to ADDR so they are high for ADDR only
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      win      <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= SEL_NONE;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_byteen <= '0;
      dm_we    <= 1'b0;
      tc1_we   <= 1'b0;
      tc2_we   <= 1'b0;
      int_we   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last     <= 1'b1;
`endif
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      dm_we  <= 1'b0;
      tc1_we <= 1'b0;
      tc2_we <= 1'b0;
      int_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            state    <= ST_ADDR;
            win      <= pick;
            s_addr   <= c_addr;
            s_wdata  <= c_wdata;
            s_byteen <= c_byteen;
            we_q     <= c_we;
            err_q    <= dec_err;
            sel_q    <= dec_sel;
            dm_we    <= stb_ok && (dec_sel == SEL_DM);
            tc1_we   <= stb_ok && (dec_sel == SEL_TC1);
            tc2_we   <= stb_ok && (dec_sel == SEL_TC2);
            int_we   <= stb_ok && (dec_sel == SEL_INT);
`ifdef MEM_ARB_RR_EN
            last     <= pick;
`endif
          end
        end
        ST_ADDR: begin
          state   <= ST_RESP;
          m0_ack  <= ~win;
          m1_ack  <= win;
          m_err   <= err_q;
          m_rdata <= rd_sel;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk in 1, single clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have ports m0_req in 1, m0_addr in 32, m0_we in 1, m0_byteen in 4, m0_wdata in 32: CPU data master (priority master).
REQ-003 SHALL have ports m1_req in 1, m1_addr in 32, m1_we in 1, m1_byteen in 4, m1_wdata in 32: secondary master (loader/debug).
REQ-004 SHALL have ports m0_ack out 1, m1_ack out 1, m_err out 1, m_rdata out 32: response pulse, error flag and read data, shared by both masters.
REQ-005 SHALL have ports s_addr out 32, s_wdata out 32, s_byteen out 4, dm_we out 1, tc1_we out 1, tc2_we out 1, int_we out 1: slave write strobes.
REQ-006 SHALL have ports dm_rdata in 32, tc1_rdata in 32, tc2_rdata in 32, int_rdata in 32: slave read data, valid combinationally in the ADDR cycle.
REQ-007 SHALL have port m0_stall out 1: high while m0_req=1 and m0 has not yet been acked.

Function
REQ-008 SHALL implement FSM IDLE -> ADDR -> RESP -> IDLE, one transfer per 3 cycles.
REQ-009 In IDLE with any req: SHALL latch winner id, addr, we, byteen and wdata, then go to ADDR. With no req: SHALL stay in IDLE.
REQ-010 Request rule: a master SHALL hold req and its fields stable until its ack. The latched copy SHALL be used regardless.
REQ-011 Address map: DM 0x0000_0000-0x0000_2fff; TC1 0x0000_7f00-0x0000_7f0b; TC2 0x0000_7f10-0x0000_7f1b; INT 0x0000_7f20-0x0000_7f23. Decode SHALL be inclusive at both bounds.
REQ-012 In ADDR: s_addr, s_wdata and s_byteen SHALL show the latched values. Exactly one slave *_we SHALL be high, and only if we=1, the address decodes and no error applies.
REQ-013 Error SHALL be flagged in each of these cases:
- address outside the map;
- byteen not 4'b1111 for a TC1/TC2 target;
- a write to TC1/TC2 offset 0x8-0xb (COUNT).
On error no *_we SHALL be asserted.
REQ-014 In ADDR: SHALL register the selected slave's rdata (0 on error or write) and the error flag.
REQ-015 In RESP: SHALL pulse the winner's ack for exactly 1 cycle, with m_rdata and m_err from the registers. m_rdata and m_err SHALL hold their value until the next RESP.
REQ-016 Latency SHALL be: req seen in IDLE at cycle N -> ack at cycle N+2. Earliest next grant is cycle N+3.
REQ-017 Simultaneous m0_req and m1_req in IDLE SHALL be resolved per REQ-021/022.
REQ-018 m0_stall SHALL be combinational: m0_req & ~m0_ack.

Reset
REQ-019 On reset: state=IDLE; acks, m_err, all *_we, s_byteen and m_rdata = 0; last-winner = m1.
REQ-020 Reset asserted in ADDR or RESP SHALL abort the transfer: no ack, and no slave strobe in the following cycle.

Configuration
REQ-021 With MEM_ARB_RR_EN defined: round-robin. On conflict the master not granted last SHALL win, and the last-winner register SHALL update on every grant.
REQ-022 Without MEM_ARB_RR_EN: fixed priority, m0 always wins. The last-winner register SHALL be absent.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the address bound constants, COUNT offset, FSM state enum and slave-select enum.
REQ-024 Sub-module mem_arb_decode (combinational) SHALL map addr/we/byteen to slave select and error. mem_arbiter instantiates it once.

Verification
REQ-025 m0 sw addr 0x0000_0010, byteen 1111, wdata 0xdeadbeef -> dm_we=1 for 1 cycle 1 cycle after req; m0_ack at N+2; m_err=0.
REQ-026 m0 read 0x0000_7f04, tc1_rdata=0x12 -> m0_ack at N+2, m_rdata=0x12, no *_we.
REQ-027 m1 write 0x0000_7f18 -> m_err=1 at ack, tc2_we never asserted. Also m0 read 0x0000_3000 -> m_err=1.
REQ-028 m0 and m1 both req every cycle, RR build -> acks alternate m0, m1, m0, m1 every 3 cycles. Non-RR build -> m1 never acked while m0_req=1.
REQ-029 reset pulsed in the ADDR cycle -> no ack, FSM in IDLE the next cycle. A pending req is regranted 3 cycles later.
REQ-030 m0 sh (byteen 0011) to 0x0000_7f00 -> m_err=1, tc1_we=0.
